image_resize_rd_ctrl: RTL and testbench
=======================================

// Module: image_resize_rd_ctrl
// PURPOSE
//  Read-side controller of the bicubic resize line buffer (image_line_buffer). Walks the destination
//  raster, maps each dst pixel to a source coordinate via fixed-point step accumulators, and drives
//  rd_en/rd_addr/rd_finish. Emits the bicubic fractional weights, aligned with the buffer's 4x4 window
//  output (valid_o), to the downstream bicubic interpolator. One dst pixel per cycle when unstalled.
// PARAMETERS
//  FRAC_W  16  fractional bits of step/accumulators
//  COEF_W  8   fractional bits forwarded to interpolator (MSBs of frac)
//  RD_LAT  2   rd_en -> line-buffer valid_o latency, cycles
// PORTS
//  clk            in   1        clock, single domain
//  reset          in   1        synchronous, active-high
//  start          in   1        pulse: begin frame (ignored unless IDLE)
//  src_width      in   11       source pixels/line (>=4)
//  src_height     in   11       source lines/frame (>=4)
//  dst_width      in   11       dest pixels/line (>=1)
//  dst_height     in   11       dest lines/frame (>=1)
//  x_step,y_step  in   4+FRAC_W src/dst ratio, U4.FRAC_W; sampled on start
//  src_frame_done in   1        level: every source line of frame written to buffer
//  rd_ready       in   1        line buffer: >=3 consecutive lines resident
//  ds_ready       in   1        interpolator may accept issues
//  rd_en          out  1        read strobe to line buffer
//  rd_addr        out  11       source column (window anchor)
//  rd_finish      out  1        1-cycle pulse: release current source line
//  frac_x_o       out  COEF_W   x weight index, aligned with buffer valid_o
//  frac_y_o       out  COEF_W   y weight index, aligned
//  eol_o,eof_o    out  1        last pixel of dst line / dst frame, aligned
//  busy           out  1        high from start accept until DONE->IDLE
//  frame_done     out  1        1-cycle pulse at end of flush
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, counters/accumulators 0. Mid-frame reset aborts without flush.
//  Coords: acc_x = dst_x*x_step, acc_y = dst_y*y_step (by accumulation, no multiplier); width 11+FRAC_W,
//   no wrap. sx = acc_x>>FRAC_W, sy = acc_y>>FRAC_W; frac = acc[FRAC_W-1 -: COEF_W] (truncate).
//  rel_rows counts rd_finish pulses this frame; current buffer line == rel_rows.
//  FSM: IDLE -start-> ALIGN. ALIGN: if rel_rows<sy -> ADV, else -> WAIT.
//   ADV: one rd_finish pulse, rel_rows++, then 1 idle cycle, -> ALIGN (pulses >=2 cycles apart).
//   WAIT: -> ROW when rd_ready, or when sy>=src_height-2 && src_frame_done (bottom edge).
//   ROW: each cycle with ds_ready=1: rd_en=1, rd_addr=sx, acc_x+=x_step, dst_x++. ds_ready=0 -> hold,
//    rd_en=0. After dst_x==dst_width-1 issue: acc_x=0, dst_x=0, acc_y+=y_step, dst_y++;
//    -> FLUSH if last dst line, else -> ALIGN.
//   FLUSH: rd_finish pulses (>=2 cycles apart) until rel_rows==src_height; -> DONE.
//   DONE: frame_done=1 one cycle -> IDLE.
//  sy never exceeds src_height-1 (clamped). start while busy: ignored.
//  Alignment: frac/eol/eof pass through RD_LAT-deep shift register qualified by rd_en; valid at
//   buffer valid_o. Interpolator must absorb RD_LAT in-flight pixels after dropping ds_ready.
//  Registered outputs; rd_en/rd_addr launched same cycle as the ROW-state decision.
// CONFIGURATION
//  IMAGE_RESIZE_EDGE_CLAMP_EN defined: rd_addr = clamp(sx-1, 0, src_width-4) so 4-tap window
//   stays inside the line; frac unchanged.
//  Undefined: rd_addr = sx; edge replication is the interpolator's job.
// STRUCTURE
//  Package resize_pkg: FSM state enum, FRAC_W/COEF_W/RD_LAT, coord width localparams.
//  Sub-module resize_axis_acc (step accumulator + int/frac split + clamp), instantiated for x and y.
// TESTING
//  1:1 (src=dst=8x8, step=1.0): rd_addr 0..7 per row, frac=0, 8 rd_finish total incl. flush, frame_done.
//  2x up (src 4x4, dst 8x8, step=0.5): rd_addr 0,0,1,1,2,2,3,3; frac_x 0,0x80 alternating; frac_y likewise.
//  2x down (src 16x16, dst 8x8, step=2.0): rd_addr 0,2..14; 2 rd_finish before each dst row, gap >=2 cycles.
//  ds_ready low 3 cycles mid-row: rd_en low, rd_addr/acc held, no pixel skipped or duplicated.
//  rd_ready low at bottom with src_frame_done=1, sy=src_height-2: ROW entered; with done=0: WAIT held.
//  Reset asserted mid-ROW: next cycle all outputs 0, IDLE; new start runs clean frame.

Source files
------------

// File: rtl/resize_pkg.sv
// Shared definitions for the bicubic resize read-side controller.
//   FRAC_W : fractional bits of the U4.FRAC_W steps and coordinate accumulators
//   COEF_W : weight-index bits forwarded to the interpolator (MSBs of the fraction)
//   RD_LAT : rd_en -> line-buffer valid_o latency in cycles
//   CRD_W  : width of pixel/line coordinates
//   state_t: controller FSM states
//   tag_t  : per-pixel side information carried alongside the buffer read
package resize_pkg;

    localparam int unsigned FRAC_W = 16;
    localparam int unsigned COEF_W = 8;
    localparam int unsigned RD_LAT = 2;
    localparam int unsigned CRD_W  = 11;
    localparam int unsigned STEP_W = 4 + FRAC_W;
    localparam int unsigned ACC_W  = CRD_W + FRAC_W;

    // Encodings kept identical to the legacy localparam values.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ALIGN = 3'd1,
        ST_ADV   = 3'd2,
        ST_WAIT  = 3'd3,
        ST_ROW   = 3'd4,
        ST_FLUSH = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    typedef struct packed {
        logic              vld;
        logic              eol;
        logic              eof;
        logic [COEF_W-1:0] fx;
        logic [COEF_W-1:0] fy;
    } tag_t;

endpackage

// File: rtl/resize_axis_acc.sv
// One axis of the destination->source coordinate mapping.
// Accumulates a U4.FRAC_W step per advance; the integer part is clamped to
// 'lim' and the top COEF_W fractional bits are the weight index.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   clr        : zero the accumulator (has priority over adv)
//   adv        : add step
//   step       : U4.FRAC_W step
//   lim        : upper clamp for the integer coordinate
//   pos        : clamped integer source coordinate
//   frac       : truncated fractional weight index
module resize_axis_acc
    import resize_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              adv,
    input  logic [STEP_W-1:0] step,
    input  logic [CRD_W-1:0]  lim,
    output logic [CRD_W-1:0]  pos,
    output logic [COEF_W-1:0] frac
);

    logic [ACC_W-1:0] acc;
    logic [CRD_W-1:0] ipart;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            acc <= '0;
        end else if (adv) begin
            acc <= acc + ACC_W'(step);
        end
    end

    always_comb begin
        ipart = acc[ACC_W-1:FRAC_W];
        pos   = (ipart > lim) ? lim : ipart;
        frac  = acc[FRAC_W-1 -: COEF_W];
    end

endmodule

// File: rtl/image_resize_rd_ctrl.sv
// Read-side controller of the bicubic resize line buffer. Walks the
// destination raster, maps each dst pixel to a source coordinate, drives the
// line-buffer read strobe/address and line release, and forwards the bicubic
// weight indices aligned with the buffer's window output.
// Build option: IMAGE_RESIZE_EDGE_CLAMP_EN -> rd_addr = clamp(sx-1, 0, src_width-4)
//   so the 4-tap window stays inside the line; otherwise rd_addr = sx.
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   start              : begin frame (accepted only when idle)
//   src_/dst_width/height : frame geometry
//   x_step, y_step     : U4.FRAC_W src/dst ratios, sampled on start
//   src_frame_done     : all source lines written to the buffer
//   rd_ready           : >=3 consecutive lines resident in the buffer
//   ds_ready           : interpolator can accept issues
//   rd_en, rd_addr     : read strobe and window-anchor column
//   rd_finish          : one-cycle release of the current source line
//   frac_x_o, frac_y_o, eol_o, eof_o : per-pixel tags aligned with valid_o
//   busy, frame_done   : frame in progress / end-of-flush pulse
module image_resize_rd_ctrl
    import resize_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CRD_W-1:0]  src_width,
    input  logic [CRD_W-1:0]  src_height,
    input  logic [CRD_W-1:0]  dst_width,
    input  logic [CRD_W-1:0]  dst_height,
    input  logic [STEP_W-1:0] x_step,
    input  logic [STEP_W-1:0] y_step,
    input  logic              src_frame_done,
    input  logic              rd_ready,
    input  logic              ds_ready,
    output logic              rd_en,
    output logic [CRD_W-1:0]  rd_addr,
    output logic              rd_finish,
    output logic [COEF_W-1:0] frac_x_o,
    output logic [COEF_W-1:0] frac_y_o,
    output logic              eol_o,
    output logic              eof_o,
    output logic              busy,
    output logic              frame_done
);

    state_t            state;
    logic [STEP_W-1:0] x_step_q, y_step_q;
    logic [CRD_W-1:0]  dst_x, dst_y, rel_rows;
    logic [CRD_W-1:0]  sx, sy, addr;
    logic [COEF_W-1:0] frac_x, frac_y;
    logic              accept, issue, last_x, last_y, bottom;
    tag_t              tag_pipe [RD_LAT];

    always_comb begin
        accept = (state == ST_IDLE) && start;
        issue  = (state == ST_ROW) && ds_ready;
        last_x = (dst_x == dst_width - CRD_W'(1));
        last_y = (dst_y == dst_height - CRD_W'(1));
        // Bottom rows never get 3 resident lines; proceed once the source is complete.
        bottom = (sy >= src_height - CRD_W'(2)) && src_frame_done;
    end

`ifdef IMAGE_RESIZE_EDGE_CLAMP_EN
    always_comb begin
        if (sx == '0) begin
            addr = '0;
        end else if (sx - CRD_W'(1) > src_width - CRD_W'(4)) begin
            addr = src_width - CRD_W'(4);
        end else begin
            addr = sx - CRD_W'(1);
        end
    end
`else
    always_comb begin
        addr = sx;
    end
`endif

    resize_axis_acc u_acc_x (
        .clk   (clk),
        .reset (reset),
        .clr   (accept || (issue && last_x)),
        .adv   (issue),
        .step  (x_step_q),
        .lim   (src_width - CRD_W'(1)),
        .pos   (sx),
        .frac  (frac_x)
    );

    resize_axis_acc u_acc_y (
        .clk   (clk),
        .reset (reset),
        .clr   (accept),
        .adv   (issue && last_x),
        .step  (y_step_q),
        .lim   (src_height - CRD_W'(1)),
        .pos   (sy),
        .frac  (frac_y)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            x_step_q   <= '0;
            y_step_q   <= '0;
            dst_x      <= '0;
            dst_y      <= '0;
            rel_rows   <= '0;
            rd_en      <= 1'b0;
            rd_addr    <= '0;
            rd_finish  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            rd_en      <= 1'b0;
            rd_finish  <= 1'b0;
            frame_done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        busy     <= 1'b1;
                        x_step_q <= x_step;
                        y_step_q <= y_step;
                        dst_x    <= '0;
                        dst_y    <= '0;
                        rel_rows <= '0;
                        state    <= ST_ALIGN;
                    end
                end
                ST_ALIGN: begin
                    if (rel_rows < sy) begin
                        rd_finish <= 1'b1;
                        rel_rows  <= rel_rows + CRD_W'(1);
                        state     <= ST_ADV;
                    end else begin
                        state <= ST_WAIT;
                    end
                end
                // Pulse is visible during ADV; returning through ALIGN spaces pulses by 2.
                ST_ADV: state <= ST_ALIGN;
                ST_WAIT: begin
                    if (rd_ready || bottom) begin
                        state <= ST_ROW;
                    end
                end
                ST_ROW: begin
                    if (issue) begin
                        rd_en   <= 1'b1;
                        rd_addr <= addr;
                        if (last_x) begin
                            dst_x <= '0;
                            dst_y <= dst_y + CRD_W'(1);
                            state <= last_y ? ST_FLUSH : ST_ALIGN;
                        end else begin
                            dst_x <= dst_x + CRD_W'(1);
                        end
                    end
                end
                ST_FLUSH: begin
                    // Skip a cycle after each pulse so releases stay 2 cycles apart.
                    if (!rd_finish) begin
                        if (rel_rows < src_height) begin
                            rd_finish <= 1'b1;
                            rel_rows  <= rel_rows + CRD_W'(1);
                        end else begin
                            frame_done <= 1'b1;
                            state      <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Tags follow the read through the buffer latency; idle slots read as zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                tag_pipe[i] <= '0;
            end
            frac_x_o <= '0;
            frac_y_o <= '0;
            eol_o    <= 1'b0;
            eof_o    <= 1'b0;
        end else begin
            tag_pipe[0] <= issue ? tag_t'{vld: 1'b1, eol: last_x, eof: last_x && last_y,
                                          fx: frac_x, fy: frac_y} : '0;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
            if (tag_pipe[RD_LAT-1].vld) begin
                frac_x_o <= tag_pipe[RD_LAT-1].fx;
                frac_y_o <= tag_pipe[RD_LAT-1].fy;
                eol_o    <= tag_pipe[RD_LAT-1].eol;
                eof_o    <= tag_pipe[RD_LAT-1].eof;
            end else begin
                frac_x_o <= '0;
                frac_y_o <= '0;
                eol_o    <= 1'b0;
                eof_o    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_image_resize_rd_ctrl.sv
module tb_image_resize_rd_ctrl;
    import resize_pkg::*;

    logic        clk = 1'b0;
    logic        reset, start, src_frame_done, rd_ready, ds_ready;
    logic [10:0] src_width, src_height, dst_width, dst_height;
    logic [19:0] x_step, y_step;
    logic        rd_en, rd_finish, eol_o, eof_o, busy, frame_done;
    logic [10:0] rd_addr;
    logic [7:0]  frac_x_o, frac_y_o;

    always #5 clk = ~clk;

    image_resize_rd_ctrl dut (
        .clk(clk), .reset(reset), .start(start),
        .src_width(src_width), .src_height(src_height),
        .dst_width(dst_width), .dst_height(dst_height),
        .x_step(x_step), .y_step(y_step),
        .src_frame_done(src_frame_done), .rd_ready(rd_ready), .ds_ready(ds_ready),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_finish(rd_finish),
        .frac_x_o(frac_x_o), .frac_y_o(frac_y_o), .eol_o(eol_o), .eof_o(eof_o),
        .busy(busy), .frame_done(frame_done)
    );

    typedef struct { int addr; int fx; int fy; bit eol; bit eof; int sy; } pix_t;
    typedef struct { int due; int fx; int fy; bit eol; bit eof; } tg_t;

    int tests = 0;
    int fails = 0;

    int cyc = 0;
    bit ds_at_edge = 1'b0;
    bit prev_rst = 1'b1;
    always @(posedge clk) begin
        cyc        <= cyc + 1;
        ds_at_edge <= ds_ready;
        prev_rst   <= reset;
    end

    int     c_sw, c_sh, c_dw, c_dh;
    longint c_xs, c_ys;

    pix_t        exp_q[$];
    tg_t         pend_q[$];
    int          fin_cnt, n_iss, n_al, last_fin;
    bit          done_seen, prev_busy;
    logic [10:0] last_addr;
    int          cap_addr[16];
    int          cap_fx[16];
    int          cap_fy[16];

    task automatic chk(input string nm, input longint act, input longint req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Expected pixel stream straight from the coordinate rules: acc = index * step.
    task automatic build_model();
        exp_q.delete();
        pend_q.delete();
        fin_cnt   = 0;
        n_iss     = 0;
        n_al      = 0;
        done_seen = 1'b0;
        last_fin  = -10;
        for (int y = 0; y < c_dh; y++) begin
            longint ay;
            int     syv;
            ay  = longint'(y) * c_ys;
            syv = int'(ay >> 16);
            if (syv > c_sh - 1) syv = c_sh - 1;
            for (int x = 0; x < c_dw; x++) begin
                longint ax;
                pix_t   p;
                int     a;
                ax = longint'(x) * c_xs;
                a  = int'(ax >> 16);
`ifdef IMAGE_RESIZE_EDGE_CLAMP_EN
                a = a - 1;
                if (a < 0) a = 0;
                if (a > c_sw - 4) a = c_sw - 4;
`endif
                p.addr = a;
                p.fx   = int'((ax >> 8) & 255);
                p.fy   = int'((ay >> 8) & 255);
                p.eol  = (x == c_dw - 1);
                p.eof  = (x == c_dw - 1) && (y == c_dh - 1);
                p.sy   = syv;
                exp_q.push_back(p);
            end
        end
    endtask

    task automatic mon_step();
        pix_t p;
        tg_t  t;
        if (busy && !prev_busy) build_model();
        prev_busy = busy;
        if (prev_rst) begin
            pend_q.delete();
            last_addr = rd_addr;
            return;
        end
        if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
            t = pend_q.pop_front();
            chk("frac_x_o", frac_x_o, t.fx);
            chk("frac_y_o", frac_y_o, t.fy);
            chk("eol_o", eol_o, t.eol);
            chk("eof_o", eof_o, t.eof);
            if (n_al < 16) begin
                cap_fx[n_al] = frac_x_o;
                cap_fy[n_al] = frac_y_o;
            end
            n_al++;
        end else begin
            chk("tags_idle", {frac_x_o, frac_y_o, eol_o, eof_o}, 0);
        end
        if (rd_en) begin
            chk("issue_expected", exp_q.size() > 0, 1);
            chk("busy_on_issue", busy, 1);
            chk("rd_en_needs_ds_ready", ds_at_edge, 1);
            if (exp_q.size() > 0) begin
                p = exp_q.pop_front();
                chk("rd_addr", rd_addr, p.addr);
                chk("line_at_issue", fin_cnt, p.sy);
                t = '{due: cyc + RD_LAT, fx: p.fx, fy: p.fy, eol: p.eol, eof: p.eof};
                pend_q.push_back(t);
            end
            if (n_iss < 16) cap_addr[n_iss] = rd_addr;
            n_iss++;
        end else begin
            chk("rd_addr_hold", rd_addr, last_addr);
        end
        if (rd_finish) begin
            chk("rd_finish_gap", (cyc - last_fin) >= 2, 1);
            last_fin = cyc;
            fin_cnt++;
        end
        if (frame_done) begin
            chk("finish_total", fin_cnt, c_sh);
            chk("all_issued", exp_q.size(), 0);
            chk("busy_at_done", busy, 1);
            done_seen = 1'b1;
        end
        last_addr = rd_addr;
    endtask

    task automatic start_frame(input int sw, input int sh, input int dw, input int dh,
                               input longint xs, input longint ys);
        c_sw = sw; c_sh = sh; c_dw = dw; c_dh = dh; c_xs = xs; c_ys = ys;
        src_width  = 11'(sw);
        src_height = 11'(sh);
        dst_width  = 11'(dw);
        dst_height = 11'(dh);
        x_step     = 20'(xs);
        y_step     = 20'(ys);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_iss(input int n);
        for (int i = 0; i < 5000 && n_iss < n; i++) @(negedge clk);
        chk("issue_wait_bound", n_iss >= n, 1);
    endtask

    task automatic wait_done();
        @(negedge clk);
        for (int i = 0; i < 20000 && !done_seen; i++) @(negedge clk);
        chk("frame_done_seen", done_seen, 1);
        @(negedge clk);
    endtask

    task automatic chk_quiet(input string nm);
        chk(nm, {rd_en, rd_addr, rd_finish, frac_x_o, frac_y_o, eol_o, eof_o, frame_done}, 0);
        chk({nm, "_busy"}, busy, 0);
    endtask

    initial begin
        int v0;
        int up_addr[8];
        up_addr = '{0, 0, 1, 1, 2, 2, 3, 3};
        reset = 1'b1; start = 1'b0; src_frame_done = 1'b0; rd_ready = 1'b1; ds_ready = 1'b1;
        src_width = '0; src_height = '0; dst_width = '0; dst_height = '0;
        x_step = '0; y_step = '0;
        prev_busy = 1'b0; last_addr = '0; n_iss = 0; done_seen = 1'b0; fin_cnt = 0;
        fork
            forever begin
                @(negedge clk);
                mon_step();
            end
        join_none
        repeat (3) @(negedge clk);
        chk_quiet("reset_state");
        reset = 1'b0;
        @(negedge clk);

        // 1:1 with a 3-cycle downstream stall mid-row
        start_frame(8, 8, 8, 8, 64'h10000, 64'h10000);
        wait_iss(3);
        ds_ready = 1'b0;
        @(negedge clk);
        v0 = n_iss;
        repeat (2) @(negedge clk);
        chk("stall_no_issue", n_iss, v0);
        ds_ready = 1'b1;
        wait_done();
        chk("one2one_finishes", fin_cnt, 8);
        chk("one2one_issues", n_iss, 64);
`ifndef IMAGE_RESIZE_EDGE_CLAMP_EN
        for (int i = 0; i < 8; i++) chk("one2one_addr", cap_addr[i], i);
`endif

        // 2x upscale
        start_frame(4, 4, 8, 8, 64'h08000, 64'h08000);
        wait_done();
`ifndef IMAGE_RESIZE_EDGE_CLAMP_EN
        for (int i = 0; i < 8; i++) chk("up_addr", cap_addr[i], up_addr[i]);
`endif
        for (int i = 0; i < 8; i++) chk("up_frac_x", cap_fx[i], (i % 2 == 1) ? 128 : 0);
        chk("up_frac_y_row0", cap_fy[0], 0);
        chk("up_frac_y_row1", cap_fy[8], 128);
        chk("up_finishes", fin_cnt, 4);

        // 2x downscale, with a start pulse while busy that must be ignored
        start_frame(16, 16, 8, 8, 64'h20000, 64'h20000);
        wait_iss(10);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
`ifndef IMAGE_RESIZE_EDGE_CLAMP_EN
        for (int i = 0; i < 8; i++) chk("down_addr", cap_addr[i], 2 * i);
`endif
        chk("down_finishes", fin_cnt, 16);
        chk("down_issues", n_iss, 64);

        // bottom edge: rd_ready withdrawn, progress only once the source frame is done
        start_frame(4, 4, 4, 4, 64'h10000, 64'h10000);
        wait_iss(8);
        rd_ready = 1'b0;
        repeat (30) @(negedge clk);
        chk("bottom_wait_held", n_iss, 8);
        chk("bottom_busy", busy, 1);
        src_frame_done = 1'b1;
        wait_done();
        chk("bottom_issues", n_iss, 16);
        src_frame_done = 1'b0;
        rd_ready = 1'b1;

        // reset in the middle of a row, then a clean frame
        start_frame(8, 8, 8, 8, 64'h10000, 64'h10000);
        wait_iss(5);
        reset = 1'b1;
        @(negedge clk);
        chk_quiet("midrow_reset");
        reset = 1'b0;
        @(negedge clk);
        start_frame(8, 8, 8, 8, 64'h10000, 64'h10000);
        wait_done();
        chk("after_reset_finishes", fin_cnt, 8);
        chk("after_reset_issues", n_iss, 64);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
